// File: rtl/shared_mem_responder_pkg.sv
// Shared types and constants for the two-port memory responder: bus request
// encodings, word/address widths, FSM state type and port indices.
package shared_mem_responder_pkg;

    localparam int IOSTATEWIDTH = 2;
    localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'd0;
    localparam logic [IOSTATEWIDTH-1:0] RD   = 2'd1;
    localparam logic [IOSTATEWIDTH-1:0] WT   = 2'd2;

    localparam int ADDRWIDTH = 8;
    localparam int WORDWIDTH = 8;

    localparam int MEMSTATEWIDTH = 1;
    typedef enum logic [MEMSTATEWIDTH-1:0] {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_e;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

    function automatic logic rw_is_legal(input logic [IOSTATEWIDTH-1:0] rw);
        return (rw == RD) || (rw == WT);
    endfunction

endpackage

// File: rtl/shared_mem_responder_mem_req_slot.sv
// One port's request slot: captures a request, holds it until the engine
// completes it, then holds the sticky response until the next request.
module mem_req_slot
    import shared_mem_responder_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IOSTATEWIDTH-1:0] rw_i,
    input  logic [ADDRWIDTH-1:0]    addr_i,
    input  logic [WORDWIDTH-1:0]    wdata_i,
    input  logic                    done_i,
    input  logic [WORDWIDTH-1:0]    rdata_i,
    output logic                    pend_o,
    output logic [IOSTATEWIDTH-1:0] op_o,
    output logic [ADDRWIDTH-1:0]    addr_o,
    output logic [WORDWIDTH-1:0]    wdata_o,
    output logic                    read_en_o,
    output logic                    write_done_o,
    output logic [WORDWIDTH-1:0]    rdata_o,
    output logic                    req_err_o
);

    logic                    pend_q, pend_d;
    logic [IOSTATEWIDTH-1:0] op_q, op_d;
    logic [ADDRWIDTH-1:0]    addr_q, addr_d;
    logic [WORDWIDTH-1:0]    wdata_q, wdata_d;
    logic                    read_en_q, read_en_d;
    logic                    write_done_q, write_done_d;
    logic [WORDWIDTH-1:0]    rdata_q, rdata_d;
    logic                    req_err_q, req_err_d;
    logic                    legal;

    always_comb begin
        pend_d       = pend_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        read_en_d    = read_en_q;
        write_done_d = write_done_q;
        rdata_d      = rdata_q;
        req_err_d    = req_err_q;
        legal        = rw_is_legal(rw_i);

        // Completion only happens while pending, so it never collides with a capture.
        if (done_i) begin
            pend_d = 1'b0;
            if (op_q == RD) begin
                read_en_d = 1'b1;
                rdata_d   = rdata_i;
            end else begin
                write_done_d = 1'b1;
            end
        end

        if (legal && !pend_q) begin
            pend_d       = 1'b1;
            op_d         = rw_i;
            addr_d       = addr_i;
            wdata_d      = wdata_i;
            read_en_d    = 1'b0;
            write_done_d = 1'b0;
            rdata_d      = '0;
        end

        if ((legal && pend_q) || (!legal && rw_i != IDEL))
            req_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q       <= 1'b0;
            op_q         <= IDEL;
            addr_q       <= '0;
            wdata_q      <= '0;
            read_en_q    <= 1'b0;
            write_done_q <= 1'b0;
            rdata_q      <= '0;
            req_err_q    <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            read_en_q    <= read_en_d;
            write_done_q <= write_done_d;
            rdata_q      <= rdata_d;
            req_err_q    <= req_err_d;
        end
    end

    assign pend_o       = pend_q;
    assign op_o         = op_q;
    assign addr_o       = addr_q;
    assign wdata_o      = wdata_q;
    assign read_en_o    = read_en_q;
    assign write_done_o = write_done_q;
    assign rdata_o      = rdata_q;
    assign req_err_o    = req_err_q;

endmodule

// File: rtl/shared_mem_responder.sv
// Two-port memory responder: round-robin arbiter, fixed-latency access engine
// and DEPTH-word backing store shared by both cache controllers.
module shared_mem_responder
    import shared_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IOSTATEWIDTH-1:0] rw0,
    input  logic [ADDRWIDTH-1:0]    addr0,
    input  logic [WORDWIDTH-1:0]    wdata0,
    output logic                    readEn0,
    output logic                    writeDone0,
    output logic [WORDWIDTH-1:0]    rdata0,
    input  logic [IOSTATEWIDTH-1:0] rw1,
    input  logic [ADDRWIDTH-1:0]    addr1,
    input  logic [WORDWIDTH-1:0]    wdata1,
    output logic                    readEn1,
    output logic                    writeDone1,
    output logic [WORDWIDTH-1:0]    rdata1,
    output logic                    busy,
    output logic [1:0]              reqErr
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0][IOSTATEWIDTH-1:0] rw_a, op_a;
    logic [1:0][ADDRWIDTH-1:0]    addr_in_a, addr_a;
    logic [1:0][WORDWIDTH-1:0]    wdata_in_a, wdata_a, rdata_a;
    logic [1:0]                   pend_a, done_a, read_en_a, write_done_a, req_err_a;

    mem_state_e          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rr_q, rr_d;
    logic                gnt_q, gnt_d;
    logic                access_done;
    logic                mem_we;
    logic [IDXW-1:0]     sel_idx;
    logic [WORDWIDTH-1:0] rd_word;
    logic [WORDWIDTH-1:0] mem_q [DEPTH];

    assign rw_a[PORT0]       = rw0;
    assign rw_a[PORT1]       = rw1;
    assign addr_in_a[PORT0]  = addr0;
    assign addr_in_a[PORT1]  = addr1;
    assign wdata_in_a[PORT0] = wdata0;
    assign wdata_in_a[PORT1] = wdata1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            mem_req_slot u_slot (
                .clk          (clk),
                .reset        (reset),
                .rw_i         (rw_a[gi]),
                .addr_i       (addr_in_a[gi]),
                .wdata_i      (wdata_in_a[gi]),
                .done_i       (done_a[gi]),
                .rdata_i      (rd_word),
                .pend_o       (pend_a[gi]),
                .op_o         (op_a[gi]),
                .addr_o       (addr_a[gi]),
                .wdata_o      (wdata_a[gi]),
                .read_en_o    (read_en_a[gi]),
                .write_done_o (write_done_a[gi]),
                .rdata_o      (rdata_a[gi]),
                .req_err_o    (req_err_a[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        case (state_q)
            MEM_IDLE: begin
                if (pend_a[PORT0] || pend_a[PORT1]) begin
                    state_d = MEM_ACCESS;
                    cnt_d   = CNT_LOAD;
                    if (pend_a[PORT0] && pend_a[PORT1]) begin
                        gnt_d = rr_q;
                        rr_d  = ~rr_q;
                    end else begin
                        gnt_d = pend_a[PORT1];
                    end
                end
            end
            MEM_ACCESS: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = MEM_IDLE;
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == MEM_ACCESS);
        access_done = (state_q == MEM_ACCESS) && (cnt_q == 4'd0);
        done_a      = 2'b00;
        if (access_done) done_a[gnt_q] = 1'b1;
        mem_we      = access_done && (op_a[gnt_q] == WT);
    end

    // Upper address bits are dropped, so addresses alias modulo DEPTH.
    assign sel_idx = IDXW'(addr_a[gnt_q]);
    assign rd_word = mem_q[sel_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[sel_idx] <= wdata_a[gnt_q];
        end
    end

    assign readEn0    = read_en_a[PORT0];
    assign writeDone0 = write_done_a[PORT0];
    assign rdata0     = rdata_a[PORT0];
    assign readEn1    = read_en_a[PORT1];
    assign writeDone1 = write_done_a[PORT1];
    assign rdata1     = rdata_a[PORT1];
    assign reqErr     = req_err_a;

endmodule

// File: doc/shared_mem_responder.md
Name: shared_mem_responder

Overview:
- Memory-side responder for the two-cache snooping system. It serves the rwToMem/addrToMem/dataToMem requests issued by both cache controllers.
- Holds a DEPTH-word backing store and arbitrates round-robin between the two ports.
- Each access completes after a fixed LATENCY. Completion is signalled with readEn (reads) or writeDone (writes) back to the requesting cache.

Parameters:
- DEPTH, 16, number of words in the backing store; power of two.
- LATENCY, 4, service cycles per access; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- rw0  in  `IOSTATEWIDTH  port-0 request: `IDEL / `RD / `WT (from cache 0 rwToMem)
- addr0  in  `ADDRWIDTH  port-0 address
- wdata0  in  `WORDWIDTH  port-0 write data
- readEn0  out  1  port-0 read complete (sticky)
- writeDone0  out  1  port-0 write complete (sticky)
- rdata0  out  `WORDWIDTH  port-0 read data
- rw1, addr1, wdata1, readEn1, writeDone1, rdata1: same as port 0, for cache 1
- busy  out  1  access engine not IDLE
- reqErr  out  2  per-port sticky protocol error

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset state:
  - All outputs are 0 and rdata0/1 are 0.
  - Pending flags are cleared, the RR pointer selects port 0, and the FSM is IDLE.
  - All DEPTH words are cleared to 0.
- Reset mid-access aborts the access: no response is produced and no array write occurs.
- Request capture:
  - Any cycle with rwN != `IDEL and pendN == 0 is a request.
  - At that edge the responder latches op, addr and wdata into the port-N slot and sets pendN.
  - The same edge clears readEnN, writeDoneN and the held rdataN.
  - Requests are single-cycle pulses; rwN returning to `IDEL afterwards has no effect.
- Request while pendN == 1 is an error: it is ignored, reqErr[N] is set (cleared only by reset), and the in-flight request is unaffected.
- Address mapping: the index is addr[log2(DEPTH)-1:0]. Upper bits are ignored, so addresses alias modulo DEPTH.
- FSM states: IDLE, ACCESS.
- IDLE:
  - If exactly one pend is set, that port is granted.
  - If both are set, the port indicated by the RR pointer is granted, and the pointer flips to the other port.
  - On a grant, next state is ACCESS and cnt is loaded with LATENCY-1.
  - A request captured at the same edge is not visible for grant until the next cycle.
- ACCESS:
  - If cnt != 0, cnt is decremented.
  - If cnt == 0, the access is performed:
    - RD: rdataN <= mem[idx]; readEnN <= 1.
    - WT: mem[idx] <= wdata; writeDoneN <= 1.
  - In both cases pendN is cleared and next state is IDLE.
- Latency: for a request in cycle 0 with the engine idle and no contention, the response is first visible in cycle LATENCY+2 (cycle 6 at default).
- Contention: the losing port is served back-to-back. Its response appears LATENCY+1 cycles after the winner's.
- Sticky responses: readEnN/writeDoneN and rdataN hold until port N issues its next request. This is required because caches may wait several cycles for allowRead before consuming the response.
- Ordering:
  - Accesses to the same index are applied in grant order.
  - A read granted after a write returns the written value.
  - Two simultaneous writes: the later-granted write wins.
- Simultaneous request capture on both ports in the same cycle is legal; both slots latch.
- An illegal rw encoding (not `IDEL/`RD/`WT) is treated as a request error: ignored, and reqErr[N] is set.

Decomposition:
- def.v already supplies `IOSTATEWIDTH, `RD, `WT, `IDEL, `ADDRWIDTH and `WORDWIDTH.
- Add to the shared package:
  - `MEMSTATEWIDTH=1
  - `MEM_IDLE, `MEM_ACCESS
  - `PORT0/`PORT1 indices
- One sub-module is natural: mem_req_slot, instantiated twice. It holds the per-port pend/op/addr/wdata capture, the sticky response flags, rdata hold and reqErr. The top level holds the arbiter, FSM, counter and array.

Test Plan (all at defaults: LATENCY=4, DEPTH=16):
- Write then read, single port: port0 WT addr 3 data 0xA5 at cycle 0 → writeDone0 rises in cycle 6. Port0 RD addr 3 → readEn0 rises 6 cycles later with rdata0 = 0xA5; writeDone0 clears at the RD capture edge.
- Simultaneous contention: both ports RD in the same cycle after reset → port0 responds at cycle 6 and port1 at cycle 11. Repeating both RDs → port1 is served first (RR flip).
- Ordering across ports: port0 WT addr 5 = 0x11 and port1 WT addr 5 = 0x22 in the same cycle; afterwards port0 RD addr 5 → returns 0x22.
- Sticky hold: port1 RD completes, rw1 held `IDEL for 10 cycles → readEn1 stays 1 and rdata1 stays stable throughout.
- Protocol error and aliasing:
  - port0 issues a second RD while pending → ignored, reqErr[0]=1, and the original response still arrives.
  - WT addr 0x13 then RD addr 0x03 → same word is returned.
- Reset mid-access: reset asserted in cycle 3 of a WT addr 7 = 0xFF → no writeDone0; a subsequent RD addr 7 returns 0, and all outputs read 0 in the cycle after reset.
